// File: rtl/mdu_issue_if.sv
// mdu_issue_if: E/D-stage request and MDU issue/stall status bundle for mdu_issue_ctrl.
interface mdu_issue_if;
  logic        e_valid;
  logic [3:0]  e_op;
  logic        d_md_use;
  logic [3:0]  mdu_op;
  logic        mdu_start;
  logic        busy;
  logic        stall;
  logic [31:0] stall_cnt;
  logic [31:0] op_cnt;
  logic        chk_err;
  modport master (
    output e_valid, e_op, d_md_use,
    input  mdu_op, mdu_start, busy, stall, stall_cnt, op_cnt, chk_err
  );
  modport slave (
    input  e_valid, e_op, d_md_use,
    output mdu_op, mdu_start, busy, stall, stall_cnt, op_cnt, chk_err
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: MDU op/start issue, occupancy mirror, D-stage stall and perf counters.
// Defining MDU_CHECK_EN adds a sticky chk_err for start collisions and undefined opcodes.
module mdu_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input logic clk,
  input logic reset,
  mdu_issue_if.slave io
);
  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV} state_e;
  if (MUL_LAT < 1 || MUL_LAT > 15 || DIV_LAT < 1 || DIV_LAT > 15 ||
      (1 << CNT_W) <= (MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT)) begin : g_bad_param
    $error("mdu_issue_ctrl: latency out of range or CNT_W too narrow");
  end
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d, op_cnt_q, op_cnt_d;
  logic is_mul, is_div, start_req, busy, start, stall;
  always_comb begin
    is_mul    = io.e_op inside {4'd1, 4'd2, 4'd9, 4'd10};
    is_div    = io.e_op inside {4'd3, 4'd4};
    start_req = io.e_valid & (is_mul | is_div);
    busy      = state_q != IDLE;
    start     = start_req & ~busy;
    stall     = io.d_md_use & (start | busy);
  end
  // Countdown holds the remaining busy cycles; the cycle with cnt==1 is the last busy one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = is_mul ? RUN_MUL : RUN_DIV;
        cnt_d   = is_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
      end
    end else if (cnt_q == CNT_W'(1)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    op_cnt_d    = (start && !(&op_cnt_q)) ? op_cnt_q + 32'd1 : op_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      op_cnt_q    <= op_cnt_d;
    end
  end
  assign io.mdu_op    = io.e_valid ? io.e_op : 4'd0;
  assign io.mdu_start = start;
  assign io.busy      = busy;
  assign io.stall     = stall;
  assign io.stall_cnt = stall_cnt_q;
  assign io.op_cnt    = op_cnt_q;
`ifdef MDU_CHECK_EN
  logic chk_err_q, chk_err_d, chk_hit;
  always_comb begin
    chk_hit   = io.e_valid & ((start_req & busy) | (io.e_op inside {[4'd11:4'd14]}));
    chk_err_d = chk_err_q | chk_hit;
  end
  always_ff @(posedge clk) begin
    if (reset) chk_err_q <= 1'b0;
    else chk_err_q <= chk_err_d;
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && chk_hit) $display("mdu_issue_ctrl: warning: MDU collision/undefined op at %0t", $time);
  end
`endif
  assign io.chk_err = chk_err_q;
`else
  assign io.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// tb_mdu_issue_ctrl: scenario and randomized checks of mdu_issue_ctrl against a cycle-number reference model.
module tb_mdu_issue_ctrl;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  longint cyc = 0;
  longint busy_end = -1;
  logic [31:0] m_sc = '0, m_oc = '0;
  logic m_err = 1'b0;
`ifdef MDU_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  mdu_issue_if dif ();
  mdu_issue_ctrl dut (.clk(clk), .reset(reset), .io(dif));
  always #5 clk = ~clk;
  function automatic bit m_is_start(logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
  endfunction
  function automatic longint m_lat(logic [3:0] op);
    return (op == 4'd3 || op == 4'd4) ? 10 : 5;
  endfunction
  function automatic bit m_busy();
    return cyc <= busy_end;
  endfunction
  function automatic bit m_start();
    return dif.e_valid && m_is_start(dif.e_op) && !m_busy();
  endfunction
  function automatic bit m_stall();
    return dif.d_md_use && (m_start() || m_busy());
  endfunction
  task automatic drive(input bit r, input bit v, input logic [3:0] op, input bit d);
    reset = r;
    dif.e_valid = v;
    dif.e_op = op;
    dif.d_md_use = d;
  endtask
  task automatic tick();
    bit st, sl, bz;
    st = m_start();
    sl = m_stall();
    bz = m_busy();
    if (reset) begin
      busy_end = cyc;
      m_sc = '0;
      m_oc = '0;
      m_err = 1'b0;
    end else begin
      if (st) busy_end = cyc + m_lat(dif.e_op);
      if (sl && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (st && m_oc != 32'hFFFF_FFFF) m_oc = m_oc + 1;
      if (CHK && dif.e_valid && ((m_is_start(dif.e_op) && bz) || dif.e_op inside {[4'd11:4'd14]})) m_err = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic test_reset();
    drive(1, 0, 0, 1);
    repeat (3) tick();
    #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", dif.busy); end
    checks++; if (dif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", dif.stall); end
    checks++; if (dif.stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %h want 0", dif.stall_cnt); end
    checks++; if (dif.op_cnt !== 32'd0) begin errors++; $display("FAIL reset_op_cnt: got %h want 0", dif.op_cnt); end
    checks++; if (dif.mdu_op !== 4'd0) begin errors++; $display("FAIL reset_mdu_op: got %h want 0", dif.mdu_op); end
    checks++; if (dif.chk_err !== 1'b0) begin errors++; $display("FAIL reset_chk_err: got %b want 0", dif.chk_err); end
    drive(1, 1, 1, 1);
    #1;
    checks++; if (dif.mdu_start !== 1'b1) begin errors++; $display("FAIL reset_comb_start: got %b want 1", dif.mdu_start); end
    checks++; if (dif.mdu_op !== 4'd1) begin errors++; $display("FAIL reset_comb_op: got %h want 1", dif.mdu_op); end
    tick();
    drive(0, 0, 0, 0);
    #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL reset_no_start: got busy %b want 0", dif.busy); end
  endtask
  task automatic test_mult();
    drive(1, 0, 0, 0);
    tick();
    for (int k = 0; k < 12; k++) begin
      drive(0, k == 3, (k == 3) ? 4'd1 : 4'd0, k >= 3 && k <= 10);
      #1;
      checks++; if (dif.mdu_start !== (k == 3)) begin errors++; $display("FAIL mult_start[%0d]: got %b want %b", k, dif.mdu_start, k == 3); end
      checks++; if (dif.busy !== (k >= 4 && k <= 8)) begin errors++; $display("FAIL mult_busy[%0d]: got %b want %b", k, dif.busy, k >= 4 && k <= 8); end
      checks++; if (dif.stall !== (k >= 3 && k <= 8)) begin errors++; $display("FAIL mult_stall[%0d]: got %b want %b", k, dif.stall, k >= 3 && k <= 8); end
      tick();
    end
    checks++; if (dif.stall_cnt !== 32'd6) begin errors++; $display("FAIL mult_stall_cnt: got %0d want 6", dif.stall_cnt); end
    checks++; if (dif.op_cnt !== 32'd1) begin errors++; $display("FAIL mult_op_cnt: got %0d want 1", dif.op_cnt); end
  endtask
  task automatic test_div();
    drive(1, 0, 0, 0);
    tick();
    for (int k = 0; k < 13; k++) begin
      drive(0, k == 0, (k == 0) ? 4'd3 : 4'd0, k >= 5);
      #1;
      checks++; if (dif.busy !== (k >= 1 && k <= 10)) begin errors++; $display("FAIL div_busy[%0d]: got %b want %b", k, dif.busy, k >= 1 && k <= 10); end
      checks++; if (dif.stall !== (k >= 5 && k <= 10)) begin errors++; $display("FAIL div_mflo_stall[%0d]: got %b want %b", k, dif.stall, k >= 5 && k <= 10); end
      tick();
    end
  endtask
  task automatic test_reset_mid();
    drive(1, 0, 0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(k == 3, k == 0, (k == 0) ? 4'd4 : 4'd0, 1);
      #1;
      checks++; if (dif.busy !== (k >= 1)) begin errors++; $display("FAIL divu_busy[%0d]: got %b want %b", k, dif.busy, k >= 1); end
      tick();
    end
    drive(0, 1, 1, 0);
    #1;
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", dif.busy); end
    checks++; if (dif.mdu_start !== 1'b1) begin errors++; $display("FAIL midreset_start: got %b want 1", dif.mdu_start); end
    checks++; if (dif.stall_cnt !== 32'd0) begin errors++; $display("FAIL midreset_stall_cnt: got %h want 0", dif.stall_cnt); end
    checks++; if (dif.op_cnt !== 32'd0) begin errors++; $display("FAIL midreset_op_cnt: got %h want 0", dif.op_cnt); end
    tick();
    drive(0, 0, 0, 0);
    #1;
    checks++; if (dif.busy !== 1'b1) begin errors++; $display("FAIL midreset_mult_busy: got %b want 1", dif.busy); end
    checks++; if (dif.op_cnt !== 32'd1) begin errors++; $display("FAIL midreset_mult_op_cnt: got %0d want 1", dif.op_cnt); end
  endtask
  task automatic test_saturate();
    drive(1, 0, 0, 0);
    tick();
    drive(0, 1, 1, 1);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    m_sc = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (dif.stall !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d]: got %b want 1", k, dif.stall); end
      tick();
      drive(0, 0, 0, 1);
      #1;
      checks++; if (dif.stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_stall_cnt[%0d]: got %h want ffffffff", k, dif.stall_cnt); end
    end
    drive(1, 0, 0, 0);
    tick();
    drive(0, 1, 2, 0);
    force dut.op_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.op_cnt_q;
    m_oc = 32'hFFFF_FFFF;
    tick();
    drive(0, 0, 0, 0);
    #1;
    checks++; if (dif.op_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_op_cnt: got %h want ffffffff", dif.op_cnt); end
  endtask
  task automatic test_collision();
    drive(1, 0, 0, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(0, k == 0 || k == 2 || k == 3, (k == 0) ? 4'd1 : (k == 2) ? 4'd9 : (k == 3) ? 4'd5 : 4'd0, 0);
      #1;
      checks++; if (dif.busy !== (k >= 1 && k <= 5)) begin errors++; $display("FAIL coll_busy[%0d]: got %b want %b", k, dif.busy, k >= 1 && k <= 5); end
      checks++; if (dif.chk_err !== (CHK && k >= 3)) begin errors++; $display("FAIL coll_chk_err[%0d]: got %b want %b", k, dif.chk_err, CHK && k >= 3); end
      if (k == 2) begin
        checks++; if (dif.mdu_start !== 1'b0) begin errors++; $display("FAIL coll_start: got %b want 0", dif.mdu_start); end
        checks++; if (dif.mdu_op !== 4'd9) begin errors++; $display("FAIL coll_op: got %h want 9", dif.mdu_op); end
      end
      if (k == 3) begin
        checks++; if (dif.mdu_op !== 4'd5) begin errors++; $display("FAIL mfhi_passthru: got %h want 5", dif.mdu_op); end
      end
      tick();
    end
    checks++; if (dif.op_cnt !== 32'd1) begin errors++; $display("FAIL coll_op_cnt: got %0d want 1", dif.op_cnt); end
  endtask
  task automatic test_random();
    logic [3:0] op;
    for (int k = 0; k < 600; k++) begin
      op = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, op, 1'($urandom));
      #1;
      checks++; if (dif.mdu_op !== (dif.e_valid ? op : 4'd0)) begin errors++; $display("FAIL rnd_mdu_op[%0d]: got %h want %h", k, dif.mdu_op, dif.e_valid ? op : 4'd0); end
      checks++; if (dif.mdu_start !== m_start()) begin errors++; $display("FAIL rnd_start[%0d]: got %b want %b", k, dif.mdu_start, m_start()); end
      checks++; if (dif.busy !== m_busy()) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", k, dif.busy, m_busy()); end
      checks++; if (dif.stall !== m_stall()) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want %b", k, dif.stall, m_stall()); end
      checks++; if (dif.stall_cnt !== m_sc) begin errors++; $display("FAIL rnd_stall_cnt[%0d]: got %0d want %0d", k, dif.stall_cnt, m_sc); end
      checks++; if (dif.op_cnt !== m_oc) begin errors++; $display("FAIL rnd_op_cnt[%0d]: got %0d want %0d", k, dif.op_cnt, m_oc); end
      checks++; if (dif.chk_err !== m_err) begin errors++; $display("FAIL rnd_chk_err[%0d]: got %b want %b", k, dif.chk_err, m_err); end
      tick();
    end
  endtask
  initial begin
    drive(1, 0, 0, 0);
    test_reset();
    test_mult();
    test_div();
    test_reset_mid();
    test_saturate();
    test_collision();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
